// File: rtl/i2c_target_if.sv
// +------------------------------------------------------------------+
// | i2c_target_if : I2C pad pins and byte-wide register port bundle   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface i2c_target_if #(
  parameter int AW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_t;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_t, rd_addr, wr_stb, wr_addr, wr_data, busy
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_t, rd_addr, wr_stb, wr_addr, wr_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_target.sv
// +------------------------------------------------------------------+
// | i2c_target : I2C responder, auto-incrementing register pointer    |
// | Option macro: I2C_TARGET_GLITCH_FILTER_EN (3-sample majority)     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int         AW   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clk_en,
  i2c_target_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_ACK_A = 4'd2,
    S_PTR   = 4'd3,
    S_ACK_P = 4'd4,
    S_WDATA = 4'd5,
    S_ACK_W = 4'd6,
    S_RDATA = 4'd7,
    S_RACK  = 4'd8
  } state_t;

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
    end
  end

  logic scl_cur;
  logic sda_cur;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist;
  logic [2:0] sda_hist;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else if (clk_en) begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  assign scl_cur = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                   (scl_hist[1] & scl_hist[2]);
  assign sda_cur = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                   (sda_hist[1] & sda_hist[2]);
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  // Previous tick's sample; events compare it with the value being sampled now.
  logic scl_q;
  logic sda_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else if (clk_en) begin
      scl_q <= scl_cur;
      sda_q <= sda_cur;
    end
  end

  logic start_det;
  logic stop_det;
  logic scl_rise;
  logic scl_fall;

  assign start_det = clk_en & scl_q & scl_cur & sda_q & ~sda_cur;
  assign stop_det  = clk_en & scl_q & scl_cur & ~sda_q & sda_cur;
  assign scl_rise  = clk_en & ~scl_q & scl_cur;
  assign scl_fall  = clk_en & scl_q & ~scl_cur;

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          acked;
  logic          sda_rel;
  logic          stb;
  logic [AW-1:0] stb_addr;
  logic [7:0]    stb_data;
  logic          active;
  logic          addr_match;

  // General call (0x00) never matches, even if ADDR were set to zero.
  assign addr_match = (shreg[7:1] == ADDR) && (shreg[7:1] != 7'h00);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 8'h00;
      ptr      <= '0;
      rw       <= 1'b0;
      acked    <= 1'b0;
      sda_rel  <= 1'b1;
      stb      <= 1'b0;
      stb_addr <= '0;
      stb_data <= 8'h00;
      active   <= 1'b0;
    end else begin
      stb <= 1'b0;
      if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_rel <= 1'b1;
      end else if (stop_det) begin
        state   <= S_IDLE;
        sda_rel <= 1'b1;
        active  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_cur};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              case (state)
                S_ADDR: begin
                  if (addr_match) begin
                    state   <= S_ACK_A;
                    sda_rel <= 1'b0;
                    rw      <= shreg[0];
                    active  <= 1'b1;
                  end else begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                  end
                end
                S_PTR: begin
                  ptr     <= shreg[AW-1:0];
                  state   <= S_ACK_P;
                  sda_rel <= 1'b0;
                end
                default: begin
                  state   <= S_ACK_W;
                  sda_rel <= 1'b0;
                end
              endcase
            end
          end
          S_ACK_A: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shreg   <= bus.rd_data;
                sda_rel <= bus.rd_data[7];
                state   <= S_RDATA;
              end else begin
                sda_rel <= 1'b1;
                state   <= S_PTR;
              end
            end
          end
          S_ACK_P: begin
            if (scl_fall) begin
              sda_rel <= 1'b1;
              bit_cnt <= 4'd0;
              state   <= S_WDATA;
            end
          end
          S_ACK_W: begin
            if (scl_fall) begin
              stb      <= 1'b1;
              stb_addr <= ptr;
              stb_data <= shreg;
              ptr      <= ptr + AW'(1);
              sda_rel  <= 1'b1;
              bit_cnt  <= 4'd0;
              state    <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_rel <= 1'b1;
                bit_cnt <= 4'd0;
                acked   <= 1'b0;
                state   <= S_RACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_rel <= shreg[6];
              end
            end
          end
          S_RACK: begin
            if (scl_rise) begin
              if (sda_cur) begin
                state <= S_IDLE;
              end else begin
                ptr   <= ptr + AW'(1);
                acked <= 1'b1;
              end
            end else if (scl_fall && acked) begin
              acked   <= 1'b0;
              shreg   <= bus.rd_data;
              sda_rel <= bus.rd_data[7];
              bit_cnt <= 4'd0;
              state   <= S_RDATA;
            end
          end
          default: begin
            state   <= S_IDLE;
            sda_rel <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.sda_t   = sda_rel;
  assign bus.rd_addr = ptr;
  assign bus.wr_stb  = stb;
  assign bus.wr_addr = stb_addr;
  assign bus.wr_data = stb_data;
  assign bus.busy    = active;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// +------------------------------------------------------------------+
// | tb_i2c_target : bus-level bench for i2c_target                    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_i2c_target;
  localparam int AW = 4;
  localparam int H  = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic clk_en = 1'b0;
  int   div    = 0;
  logic scl_m  = 1'b1;
  logic sda_m  = 1'b1;

  i2c_target_if #(.AW(AW)) bif ();

  assign bif.scl_i   = scl_m;
  assign bif.sda_i   = sda_m & bif.sda_t;
  assign bif.rd_data = {4'hB, bif.rd_addr};

  i2c_target #(.ADDR(7'h50), .AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .clk_en (clk_en),
    .bus    (bif)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div    = (div == 2) ? 0 : div + 1;
      clk_en = (div == 0);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, required normal finish");
    $fatal(1);
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [11:0] wr_q[$];
  logic [11:0] exp_w[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  exp_r[$];
  bit          ack_q[$];
  bit          sda_low_seen = 1'b0;
  bit          busy_seen    = 1'b0;
  bit          stb_long     = 1'b0;
  bit          prev_stb     = 1'b0;
  logic [7:0]  txd[4];

  always @(negedge clk) begin
    if (bif.wr_stb) wr_q.push_back({bif.wr_addr, bif.wr_data});
    if (bif.wr_stb && prev_stb) stb_long = 1'b1;
    prev_stb = bif.wr_stb;
    if (!bif.sda_t) sda_low_seen = 1'b1;
    if (bif.busy) busy_seen = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (clk_en) k++;
    end
    @(negedge clk);
  endtask

  task automatic bit_w(input bit b, input bit spike);
    sda_m = b;
    wait_ticks(H / 2);
    scl_m = 1'b1;
    if (spike) begin
      wait_ticks(3);
      scl_m = 1'b0;
      wait_ticks(1);
      scl_m = 1'b1;
      wait_ticks(H - 4);
    end else begin
      wait_ticks(H);
    end
    scl_m = 1'b0;
    wait_ticks(H / 2);
  endtask

  task automatic bit_r(output bit b);
    sda_m = 1'b1;
    wait_ticks(H / 2);
    scl_m = 1'b1;
    wait_ticks(H / 2);
    b = bif.sda_i;
    wait_ticks(H / 2);
    scl_m = 1'b0;
    wait_ticks(H / 2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_ticks(H / 2);
    scl_m = 1'b1;
    wait_ticks(H / 2);
    sda_m = 1'b0;
    wait_ticks(H / 2);
    scl_m = 1'b0;
    wait_ticks(H / 2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_ticks(H / 2);
    scl_m = 1'b1;
    wait_ticks(H / 2);
    sda_m = 1'b1;
    wait_ticks(H);
  endtask

  task automatic byte_w(input logic [7:0] b, input int spike_bit);
    bit a;
    for (int i = 0; i < 8; i++) bit_w(b[7-i], i == spike_bit);
    bit_r(a);
    ack_q.push_back(a);
  endtask

  task automatic byte_r(input bit nack);
    logic [7:0] v;
    bit x;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_r(x);
      v = {v[6:0], x};
    end
    rd_q.push_back(v);
    bit_w(nack, 1'b0);
  endtask

  task automatic tx_write(input logic [7:0] abyte, input logic [7:0] p, input int n);
    i2c_start();
    byte_w(abyte, -1);
    byte_w(p, -1);
    for (int i = 0; i < n; i++) byte_w(txd[i], -1);
    i2c_stop();
  endtask

  task automatic tx_rread(input logic [7:0] p, input int n);
    i2c_start();
    byte_w(8'hA0, -1);
    byte_w(p, -1);
    i2c_start();
    byte_w(8'hA1, -1);
    for (int i = 0; i < n; i++) byte_r(i == n - 1);
    i2c_stop();
  endtask

  task automatic tx_cread(input int n);
    i2c_start();
    byte_w(8'hA1, -1);
    for (int i = 0; i < n; i++) byte_r(i == n - 1);
    i2c_stop();
  endtask

  task automatic clear_obs();
    wr_q.delete();
    rd_q.delete();
    ack_q.delete();
    exp_w.delete();
    exp_r.delete();
    sda_low_seen = 1'b0;
    busy_seen    = 1'b0;
  endtask

  task automatic compare_tx(input string tag, input bit exp_nak, input logic [3:0] eptr);
    logic [11:0] gw;
    logic [7:0]  gr;
    foreach (ack_q[i]) check($sformatf("%s_ack%0d", tag, i), 32'(ack_q[i]), 32'(exp_nak));
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++) begin
      gw = (i < wr_q.size()) ? wr_q[i] : 12'hxxx;
      check($sformatf("%s_wr%0d", tag, i), 32'(gw), 32'(exp_w[i]));
    end
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_r.size(); i++) begin
      gr = (i < rd_q.size()) ? rd_q[i] : 8'hxx;
      check($sformatf("%s_rd%0d", tag, i), 32'(gr), 32'(exp_r[i]));
    end
    check({tag, "_ptr"}, 32'(bif.rd_addr), 32'(eptr));
    check({tag, "_busy_end"}, 32'(bif.busy), 32'd0);
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(!exp_nak));
    check({tag, "_sda_low"}, 32'(sda_low_seen), 32'(!exp_nak));
    check({tag, "_stb_width"}, 32'(stb_long), 32'd0);
  endtask

  typedef struct {
    int         kind;
    logic [7:0] abyte;
    logic [7:0] p;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         exp_nak;
    int         exp_nwr;
    logic [11:0] exp_w0;
    logic [11:0] exp_w1;
    int         exp_nrd;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
    logic [3:0] exp_ptr;
  } vec_t;

  vec_t vt[8];
  int   mptr;

  initial begin
    // kind 0: write (addr byte, ptr, data); 1: ptr write + Sr + read; 2: current-pointer read
    vt[0] = '{0, 8'hA0, 8'h03, 2, 8'h5A, 8'hC3, 1'b0, 2, 12'h35A, 12'h4C3, 0, 8'h00, 8'h00, 4'h5};
    vt[1] = '{1, 8'hA0, 8'h0F, 2, 8'h00, 8'h00, 1'b0, 0, 12'h000, 12'h000, 2, 8'hBF, 8'hB0, 4'h0};
    vt[2] = '{0, 8'h42, 8'h77, 0, 8'h00, 8'h00, 1'b1, 0, 12'h000, 12'h000, 0, 8'h00, 8'h00, 4'h0};
    vt[3] = '{0, 8'hA0, 8'h1E, 2, 8'h00, 8'hFF, 1'b0, 2, 12'hE00, 12'hFFF, 0, 8'h00, 8'h00, 4'h0};
    vt[4] = '{2, 8'hA1, 8'h00, 1, 8'h00, 8'h00, 1'b0, 0, 12'h000, 12'h000, 1, 8'hB0, 8'h00, 4'h0};
    vt[5] = '{0, 8'h00, 8'h55, 0, 8'h00, 8'h00, 1'b1, 0, 12'h000, 12'h000, 0, 8'h00, 8'h00, 4'h0};
    vt[6] = '{1, 8'hA0, 8'h07, 2, 8'h00, 8'h00, 1'b0, 0, 12'h000, 12'h000, 2, 8'hB7, 8'hB8, 4'h8};
    vt[7] = '{0, 8'hA0, 8'h0A, 1, 8'h99, 8'h00, 1'b0, 1, 12'hA99, 12'h000, 0, 8'h00, 8'h00, 4'hB};

    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_t", 32'(bif.sda_t), 32'd1);
    check("rst_wr_stb", 32'(bif.wr_stb), 32'd0);
    check("rst_wr_addr", 32'(bif.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bif.wr_data), 32'd0);
    check("rst_rd_addr", 32'(bif.rd_addr), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 8; i++) begin
      clear_obs();
      if (vt[i].exp_nwr > 0) exp_w.push_back(vt[i].exp_w0);
      if (vt[i].exp_nwr > 1) exp_w.push_back(vt[i].exp_w1);
      if (vt[i].exp_nrd > 0) exp_r.push_back(vt[i].exp_r0);
      if (vt[i].exp_nrd > 1) exp_r.push_back(vt[i].exp_r1);
      txd[0] = vt[i].d0;
      txd[1] = vt[i].d1;
      case (vt[i].kind)
        0:       tx_write(vt[i].abyte, vt[i].p, vt[i].n);
        1:       tx_rread(vt[i].p, vt[i].n);
        default: tx_cread(vt[i].n);
      endcase
      compare_tx($sformatf("vec%0d", i), vt[i].exp_nak, vt[i].exp_ptr);
    end

    // STOP after four bits of a data byte: no write, pointer stays where PTR put it
    clear_obs();
    i2c_start();
    byte_w(8'hA0, -1);
    byte_w(8'h09, -1);
    bit_w(1'b1, 1'b0);
    bit_w(1'b0, 1'b0);
    bit_w(1'b1, 1'b0);
    bit_w(1'b1, 1'b0);
    i2c_stop();
    compare_tx("stopmid", 1'b0, 4'h9);

    // Reset while the target is acknowledging a data byte
    clear_obs();
    i2c_start();
    byte_w(8'hA0, -1);
    byte_w(8'h07, -1);
    for (int i = 0; i < 8; i++) bit_w(1'(8'h11 >> (7 - i)), 1'b0);
    check("rstack_driving", 32'(bif.sda_t), 32'd0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rstack_sda_t", 32'(bif.sda_t), 32'd1);
    check("rstack_rd_addr", 32'(bif.rd_addr), 32'd0);
    check("rstack_busy", 32'(bif.busy), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    begin
      bit a;
      bit_r(a);
    end
    i2c_stop();
    check("rstack_no_stb", 32'(wr_q.size()), 32'd0);
    check("rstack_ptr_after", 32'(bif.rd_addr), 32'd0);

    // Randomized transactions against a transaction-level pointer model
    mptr = 0;
    for (int t = 0; t < 12; t++) begin
      int         kind;
      int         n;
      logic [7:0] p;
      logic [6:0] a7;
      bit         nak;
      clear_obs();
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      p    = 8'($urandom_range(0, 255));
      nak  = 1'b0;
      for (int i = 0; i < 4; i++) txd[i] = 8'($urandom_range(0, 255));
      case (kind)
        0: begin
          mptr = p % 16;
          for (int i = 0; i < n; i++) begin
            exp_w.push_back({4'(mptr), txd[i]});
            mptr = (mptr + 1) % 16;
          end
          tx_write(8'hA0, p, n);
        end
        1, 2: begin
          if (kind == 1) mptr = p % 16;
          for (int i = 0; i < n; i++) begin
            exp_r.push_back(8'hB0 + 8'(mptr));
            if (i < n - 1) mptr = (mptr + 1) % 16;
          end
          if (kind == 1) tx_rread(p, n);
          else           tx_cread(n);
        end
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h50) a7 = 7'h51;
          nak = 1'b1;
          tx_write({a7, 1'($urandom_range(0, 1))}, p, 0);
        end
      endcase
      compare_tx($sformatf("rnd%0d", t), nak, 4'(mptr));
    end

    // One-sample SCL low spike in the middle of a data bit
    clear_obs();
    i2c_start();
    byte_w(8'hA0, -1);
    byte_w(8'h02, -1);
    byte_w(8'h5A, 2);
    i2c_stop();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_w.push_back(12'h25A);
    compare_tx("glitch", 1'b0, 4'h3);
`else
    check("glitch_corrupts", 32'(wr_q.size() == 1 && wr_q[0] == 12'h25A), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
